mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency memory between the core's instruction-fetch port and its load/store port.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_timeout.sv | 30 +++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// FSM states and requester identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Watchdog counter for an outstanding memory access.
// Cleared while idle, counts while granted, flags the last allowed cycle.
module mem_arb_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt;

    // Count granted cycles; restart on every new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/ack memory between fetch and data.
// One access in flight; fixed IDLE -> GRANT -> RESP sequence per access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_o,
    output logic              err_o
);

    state_t            state, state_nx;
    req_id_t           last_gnt, last_gnt_nx;
    logic              mem_req_nx, mem_we_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic              if_done_nx, d_done_nx, err_nx;
    logic [DATA_W-1:0] if_rdata_nx, d_rdata_nx;
    logic              gnt_if, gnt_d;
    logic              tmr_clr, tmr_en, tmr_exp;

    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_exp)
    );

    // Fetch wins unless data is also waiting and fetch went last.
    always_comb begin
        gnt_if = if_req & (~d_req | (last_gnt == REQ_D));
        gnt_d  = d_req & ~gnt_if;
    end

    // Next-state, memory-side request and response capture.
    always_comb begin
        state_nx     = state;
        last_gnt_nx  = last_gnt;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        if_rdata_nx  = if_rdata;
        d_rdata_nx   = d_rdata;
        if_done_nx   = 1'b0;
        d_done_nx    = 1'b0;
        err_nx       = 1'b0;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        unique case (state)
            IDLE: begin
                tmr_clr = 1'b1;
                if (gnt_if) begin
                    state_nx     = GRANT_I;
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = 1'b0;
                    mem_addr_nx  = if_addr;
                    mem_wdata_nx = '0;
                end else if (gnt_d) begin
                    state_nx     = GRANT_D;
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = d_we;
                    mem_addr_nx  = d_addr;
                    mem_wdata_nx = d_wdata;
                end
            end
            GRANT_I: begin
                tmr_en = 1'b1;
                if (mem_ack) begin
                    if_rdata_nx = mem_rdata;
                    mem_req_nx  = 1'b0;
                    if_done_nx  = 1'b1;
                    last_gnt_nx = REQ_IF;
                    state_nx    = RESP;
                end else if (tmr_exp) begin
                    if_rdata_nx = '0;
                    mem_req_nx  = 1'b0;
                    if_done_nx  = 1'b1;
                    err_nx      = 1'b1;
                    state_nx    = RESP;
                end
            end
            GRANT_D: begin
                tmr_en = 1'b1;
                if (mem_ack) begin
                    if (!mem_we) begin
                        d_rdata_nx = mem_rdata;
                    end
                    mem_req_nx  = 1'b0;
                    d_done_nx   = 1'b1;
                    last_gnt_nx = REQ_D;
                    state_nx    = RESP;
                end else if (tmr_exp) begin
                    d_rdata_nx = '0;
                    mem_req_nx = 1'b0;
                    d_done_nx  = 1'b1;
                    err_nx     = 1'b1;
                    state_nx   = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_gnt  <= REQ_D;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_nx;
            last_gnt  <= last_gnt_nx;
            mem_req   <= mem_req_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            if_done   <= if_done_nx;
            d_done    <= d_done_nx;
            if_rdata  <= if_rdata_nx;
            d_rdata   <= d_rdata_nx;
            err_o     <= err_nx;
        end
    end

    assign stall_o = (if_req | d_req) & ~(if_done | d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with directed vectors.
// Memory model and done monitor check against queued expectations.
module tb_mem_port_arbiter;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
    } rsp_t;

    logic        clk = 0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_done, d_done;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 0;
    logic [31:0] mem_rdata = 0;
    logic        stall_o, err_o;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   wcnt = 0;
    int   ack_wait = 0;
    bit   ack_en = 1;
    int   stray_cyc = -1;
    mem_t mq[$];
    rsp_t rq[$];
    int   done_cyc[$];

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall_o   (stall_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    // Cycle counter for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", n, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: acks after ack_wait cycles, checks request fields.
    always @(negedge clk) begin
        mem_t e;
        mem_ack = 0;
        if (cyc == stray_cyc) begin
            mem_ack   = 1;
            mem_rdata = 32'hFFFF_FFFF;
        end else if (mem_req && ack_en) begin
            if (wcnt >= ack_wait) begin
                wcnt    = 0;
                mem_ack = 1;
                if (mq.size() == 0) begin
                    chk("mem_unexpected_req", 1, 0);
                end else begin
                    e = mq.pop_front();
                    chk("mem_we", mem_we, e.we);
                    chk("mem_addr", mem_addr, e.addr);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    mem_rdata = e.rdata;
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Done monitor: pops expected responses on each done/err pulse.
    always @(negedge clk) begin
        rsp_t r;
        if (if_done || d_done || err_o) begin
            done_cyc.push_back(cyc);
            if (rq.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                r = rq.pop_front();
                chk("rsp_is_d", d_done, r.is_d);
                chk("rsp_is_if", if_done, !r.is_d);
                chk("rsp_err", err_o, r.err);
                if (r.is_d) chk("rsp_d_rdata", d_rdata, r.rdata);
                else        chk("rsp_if_rdata", if_rdata, r.rdata);
            end
        end
    end

    task automatic drain(string n);
        int i;
        i = 0;
        while ((if_req || d_req) && i < 40) begin
            tick();
            if (if_done) if_req = 0;
            if (d_done)  d_req = 0;
            i++;
        end
        chk(n, if_req | d_req, 0);
    endtask

    initial begin
        int n;
        int k;
        rst_n = 0;
        if_req = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        repeat (2) tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_err", err_o, 0);
        chk("rst_stall", stall_o, 0);
        rst_n = 1;
        tick();

        // Fetch only, zero-wait memory.
        if_addr = 32'h100;
        mq.push_back('{0, 32'h100, 0, 32'h0050_0093});
        rq.push_back('{0, 32'h0050_0093, 0});
        if_req = 1;
        tick();
        chk("A_mem_req_c1", mem_req, 1);
        chk("A_mem_addr", mem_addr, 32'h100);
        chk("A_stall", stall_o, 1);
        tick();
        chk("A_if_done_c2", if_done, 1);
        chk("A_mem_req_drop", mem_req, 0);
        chk("A_rdata", if_rdata, 32'h0050_0093);
        chk("A_stall_done", stall_o, 0);
        if_req = 0;
        tick();
        chk("A_done_pulse", if_done, 0);

        // Both requests at reset release; data is a store.
        rst_n = 0;
        #1;
        if_addr = 32'h200;
        d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        mq.push_back('{0, 32'h200, 0, 32'h1111_1111});
        mq.push_back('{1, 32'h40, 32'hDEAD_BEEF, 32'h5555_5555});
        rq.push_back('{0, 32'h1111_1111, 0});
        rq.push_back('{1, 32'h0, 0});
        if_req = 1; d_req = 1;
        tick();
        rst_n = 1;
        drain("B_complete");

        // Both held continuously, one wait state: strict interleave.
        ack_wait = 1;
        d_we = 0; d_wdata = 0;
        if_addr = 32'h300; d_addr = 32'h80;
        mq.push_back('{0, 32'h300, 0, 32'hA000_0000});
        mq.push_back('{0, 32'h80,  0, 32'hB000_0000});
        mq.push_back('{0, 32'h300, 0, 32'hA000_0001});
        mq.push_back('{0, 32'h80,  0, 32'hB000_0001});
        rq.push_back('{0, 32'hA000_0000, 0});
        rq.push_back('{1, 32'hB000_0000, 0});
        rq.push_back('{0, 32'hA000_0001, 0});
        rq.push_back('{1, 32'hB000_0001, 0});
        done_cyc.delete();
        if_req = 1; d_req = 1;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick();
            if (if_done || d_done) n++;
        end
        if_req = 0; d_req = 0;
        chk("C_count", n, 4);
        if (done_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk("C_spacing", done_cyc[i] - done_cyc[i-1], 4);
        end else begin
            chk("C_done_cnt", done_cyc.size(), 4);
        end
        tick();

        // No ack: timeout abort after 8 granted cycles.
        ack_en = 0;
        ack_wait = 0;
        d_addr = 32'h44;
        rq.push_back('{1, 32'h0, 1});
        d_req = 1;
        k = 0;
        while (!mem_req && k < 5) begin
            tick();
            k++;
        end
        chk("D_granted", mem_req, 1);
        k = 0;
        while (mem_req && k < 20) begin
            tick();
            k++;
        end
        chk("D_req_cycles", k, 8);
        chk("D_err", err_o, 1);
        chk("D_done", d_done, 1);
        chk("D_rdata", d_rdata, 0);
        d_req = 0;
        tick();
        chk("D_err_pulse", err_o, 0);
        tick();

        // Reset during a data grant.
        d_addr = 32'h48;
        d_req = 1;
        tick();
        chk("E_grant", mem_req, 1);
        #2;
        rst_n = 0;
        #1;
        chk("E_async_drop", mem_req, 0);
        chk("E_no_done", d_done, 0);
        if_addr = 32'h400;
        mq.push_back('{0, 32'h400, 0, 32'h0000_0013});
        mq.push_back('{0, 32'h48,  0, 32'h0000_0077});
        rq.push_back('{0, 32'h0000_0013, 0});
        rq.push_back('{1, 32'h0000_0077, 0});
        if_req = 1;
        ack_en = 1;
        tick();
        tick();
        rst_n = 1;
        drain("E_complete");
        tick();

        // Stray ack while idle is ignored.
        if_addr = 32'h500;
        mq.push_back('{0, 32'h500, 0, 32'h0000_1234});
        rq.push_back('{0, 32'h0000_1234, 0});
        if_req = 1;
        drain("F_setup");
        tick();
        tick();
        stray_cyc = cyc;
        tick();
        tick();
        chk("F_if_rdata", if_rdata, 32'h1234);
        chk("F_no_if_done", if_done, 0);
        chk("F_no_d_done", d_done, 0);
        chk("F_no_mem_req", mem_req, 0);
        if_addr = 32'h504;
        mq.push_back('{0, 32'h504, 0, 32'h0000_ABCD});
        rq.push_back('{0, 32'h0000_ABCD, 0});
        if_req = 1;
        tick();
        chk("F_idle_grant", mem_req, 1);
        chk("F_addr", mem_addr, 32'h504);
        drain("F_complete");

        repeat (3) tick();
        chk("end_mq_empty", mq.size(), 0);
        chk("end_rq_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
